// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Data-side responder for a single-cycle core. Returns load data in the
//   same cycle the address is presented. A store is committed on the rising
//   clock edge. Two regions are decoded:
//     - a word-addressed data RAM below MMIO_BASE (it aliases every DEPTH words)
//     - a small peripheral block at MMIO_BASE: a GPIO register and a
//       compare timer with an interrupt flag
//   Only whole words are handled. addr[1:0] is ignored.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset
//   addr       byte address from the core (ALU result)
//   wr_data    store data
//   mem_wr     store strobe
//   rd_data    load data, combinational from addr and registered state
//   gpio_out   GPIO output register
//   timer_irq  STATUS.flag & CTRL.irq_en
//
// Register map (offsets from MMIO_BASE):
//   0x00 GPIO[7:0]  0x04 COUNT  0x08 CTRL{irq_en,auto_reload,en}
//   0x0C COMPARE    0x10 STATUS{flag} (W1C)  0x14-0x1C reserved
module dmem_mmio_responder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        mem_wr,
    output logic [31:0] rd_data,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] SEL_GPIO    = 3'd0;
    localparam logic [2:0] SEL_COUNT   = 3'd1;
    localparam logic [2:0] SEL_CTRL    = 3'd2;
    localparam logic [2:0] SEL_COMPARE = 3'd3;
    localparam logic [2:0] SEL_STATUS  = 3'd4;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] ram_idx;
    logic          in_ram;
    logic          in_mmio;
    logic [2:0]    reg_sel;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ctrl_en;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
    logic        flag;

    logic wr_gpio, wr_count, wr_ctrl, wr_compare, wr_status;
    logic match;

    // Address decode. MMIO_BASE is 4 KiB aligned, so the 32-byte peripheral
    // window is identified by comparing the address above bit 5.
    assign ram_idx = addr[AW+1:2];
    assign in_ram  = (addr < MMIO_BASE);
    assign in_mmio = (addr[31:5] == MMIO_BASE[31:5]);
    assign reg_sel = addr[4:2];

    assign wr_gpio    = mem_wr && in_mmio && (reg_sel == SEL_GPIO);
    assign wr_count   = mem_wr && in_mmio && (reg_sel == SEL_COUNT);
    assign wr_ctrl    = mem_wr && in_mmio && (reg_sel == SEL_CTRL);
    assign wr_compare = mem_wr && in_mmio && (reg_sel == SEL_COMPARE);
    assign wr_status  = mem_wr && in_mmio && (reg_sel == SEL_STATUS);

    // A COUNT write suppresses match evaluation for that edge.
    assign match = ctrl_en && (count == compare) && !wr_count;

    // RAM has no reset. A read of the word being written sees the old value
    // because the array only changes at the edge.
    always_ff @(posedge clk) begin
        if (mem_wr && in_ram) begin
            mem[ram_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out         <= 8'h00;
            count            <= 32'h0;
            compare          <= 32'hFFFF_FFFF;
            ctrl_en          <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            flag             <= 1'b0;
        end else begin
            if (wr_gpio) begin
                gpio_out <= wr_data[7:0];
            end
            if (wr_compare) begin
                compare <= wr_data;
            end

            if (wr_count) begin
                count <= wr_data;
            end else if (match) begin
                if (ctrl_auto_reload) begin
                    count <= 32'h0;
                end
            end else if (ctrl_en) begin
                count <= count + 32'd1;
            end

            // A CTRL write overrides the one-shot auto-clear of en.
            if (wr_ctrl) begin
                ctrl_en          <= wr_data[0];
                ctrl_auto_reload <= wr_data[1];
                ctrl_irq_en      <= wr_data[2];
            end else if (match && !ctrl_auto_reload) begin
                ctrl_en <= 1'b0;
            end

            // Setting the flag wins over a simultaneous W1C.
            if (match) begin
                flag <= 1'b1;
            end else if (wr_status && wr_data[0]) begin
                flag <= 1'b0;
            end
        end
    end

    assign timer_irq = flag && ctrl_irq_en;

    always_comb begin
        rd_data = 32'h0;
        if (in_ram) begin
            rd_data = mem[ram_idx];
        end else if (in_mmio) begin
            case (reg_sel)
                SEL_GPIO:    rd_data = {24'h0, gpio_out};
                SEL_COUNT:   rd_data = count;
                SEL_CTRL:    rd_data = {29'h0, ctrl_irq_en, ctrl_auto_reload, ctrl_en};
                SEL_COMPARE: rd_data = compare;
                SEL_STATUS:  rd_data = {31'h0, flag};
                default:     rd_data = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        mem_wr;
    logic [31:0] rd_data;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int checks;
    int errors;

    dmem_mmio_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_data   (wr_data),
        .mem_wr    (mem_wr),
        .rd_data   (rd_data),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = clk_run ? ~clk : clk;

    // ---------------- reference model ----------------
    logic [31:0] m_ram   [DEPTH];
    bit          m_valid [DEPTH];
    logic [7:0]  m_gpio;
    logic [31:0] m_count, m_cmp;
    logic        m_en, m_ar, m_ie, m_flag;

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd32);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < BASE) return m_ram[word_of(a)];
        if (!is_mmio(a)) return 32'h0;
        case ((a - BASE) >> 2)
            0: return {24'h0, m_gpio};
            1: return m_count;
            2: return {29'h0, m_ie, m_ar, m_en};
            3: return m_cmp;
            4: return {31'h0, m_flag};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_gpio = 8'h0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
        m_en = 0; m_ar = 0; m_ie = 0; m_flag = 0;
    endtask

    // Effect of one rising edge on the register file, from the register rules.
    task automatic m_edge(input logic [31:0] a, input logic [31:0] d, input logic w);
        int sel;
        bit hit_match;
        logic [31:0] nxt_count;
        logic nxt_en, nxt_flag;
        sel = is_mmio(a) ? int'((a - BASE) >> 2) : -1;
        hit_match = m_en && (m_count == m_cmp) && !(w && sel == 1);
        nxt_count = m_count;
        nxt_en    = m_en;
        nxt_flag  = m_flag;
        if (w && sel == 1)      nxt_count = d;
        else if (hit_match)     nxt_count = m_ar ? 32'h0 : m_count;
        else if (m_en)          nxt_count = m_count + 1;
        if (hit_match && !m_ar) nxt_en = 1'b0;
        if (hit_match)               nxt_flag = 1'b1;
        else if (w && sel == 4 && d[0]) nxt_flag = 1'b0;
        if (w && a < BASE) begin
            m_ram[word_of(a)]   = d;
            m_valid[word_of(a)] = 1'b1;
        end
        if (w && sel == 0) m_gpio = d[7:0];
        if (w && sel == 3) m_cmp = d;
        if (w && sel == 2) begin
            nxt_en = d[0]; m_ar = d[1]; m_ie = d[2];
        end
        m_count = nxt_count;
        m_en    = nxt_en;
        m_flag  = nxt_flag;
    endtask

    // ---------------- scoreboard / checks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, check outputs mid-cycle
    // against the model (and an optional fixed value), then take the edge.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input bit has_exp = 0, input logic [31:0] exp = 0,
                       input string tag = "");
        @(negedge clk);
        addr = a; wr_data = d; mem_wr = w;
        #1;
        if (a >= BASE || m_valid[word_of(a)]) check("rd_model", rd_data, m_read(a));
        check("gpio_model", {24'h0, gpio_out}, {24'h0, m_gpio});
        check("irq_model", {31'h0, timer_irq}, {31'h0, m_flag & m_ie});
        if (has_exp) check(tag, rd_data, exp);
        @(posedge clk);
        m_edge(a, d, w);
        #1;
        mem_wr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; errors = 0;
        clk_run = 1'b1;
        addr = 0; wr_data = 0; mem_wr = 0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_reset();
        rst = 1'b0;
        #12;
        check("reset_gpio", {24'h0, gpio_out}, 32'h0);
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        addr = BASE + 32'hC; #1;
        check("reset_compare", rd_data, 32'hFFFF_FFFF);
        rst = 1'b1;

        // RAM
        cyc(32'h8, 32'hDEAD_BEEF, 1);
        cyc(32'hC, 32'h0000_1234, 1);
        cyc(32'h8, 0, 0, 1, 32'hDEAD_BEEF, "ram_08");
        cyc(32'hB, 0, 0, 1, 32'hDEAD_BEEF, "ram_0b");
        cyc(32'hC, 0, 0, 1, 32'h0000_1234, "ram_0c");
        cyc(32'h8 + 4 * DEPTH, 0, 0, 1, 32'hDEAD_BEEF, "ram_alias");
        // read-during-write returns the old word
        cyc(32'hC, 32'h5555_AAAA, 1, 1, 32'h0000_1234, "ram_rdw");
        cyc(32'hC, 32'h0000_1234, 1, 1, 32'h5555_AAAA, "ram_rdw2");

        // GPIO and unmapped
        cyc(BASE, 32'hFFFF_FFA5, 1);
        check("gpio_out", {24'h0, gpio_out}, 32'hA5);
        cyc(BASE, 0, 0, 1, 32'h0000_00A5, "gpio_rd");
        cyc(BASE + 32'h18, 32'h1234_5678, 1);
        cyc(32'h2000, 32'h1234_5678, 1);
        cyc(BASE + 32'h18, 0, 0, 1, 32'h0, "reserved_rd");
        cyc(32'h2000, 0, 0, 1, 32'h0, "unmapped_rd");

        // One-shot timer
        cyc(BASE + 32'hC, 5, 1);
        cyc(BASE + 32'h4, 0, 1);
        cyc(BASE + 32'h8, 5, 1);
        for (int i = 0; i < 6; i++) cyc(BASE + 32'h4, 0, 0, 1, i, "oneshot_count");
        check("oneshot_irq", {31'h0, timer_irq}, 32'h1);
        cyc(BASE + 32'h4, 0, 0, 1, 32'd5, "oneshot_hold");
        cyc(BASE + 32'h8, 0, 0, 1, 32'd4, "oneshot_ctrl");
        cyc(BASE + 32'h10, 1, 1);
        check("oneshot_w1c_irq", {31'h0, timer_irq}, 32'h0);

        // Auto-reload
        cyc(BASE + 32'h8, 0, 1);
        cyc(BASE + 32'hC, 3, 1);
        cyc(BASE + 32'h4, 0, 1);
        cyc(BASE + 32'h8, 3, 1);
        for (int i = 0; i < 9; i++) cyc(BASE + 32'h4, 0, 0, 1, i % 4, "reload_count");
        cyc(BASE + 32'h10, 0, 0, 1, 32'h1, "reload_flag");
        cyc(BASE + 32'h8, 0, 1);
        cyc(BASE + 32'h10, 1, 1);
        cyc(BASE + 32'h4, 32'hFFFF_FFFE, 1);
        cyc(BASE + 32'h8, 3, 1);
        cyc(BASE + 32'h4, 0, 0, 1, 32'hFFFF_FFFE, "wrap_a");
        cyc(BASE + 32'h4, 0, 0, 1, 32'hFFFF_FFFF, "wrap_b");
        cyc(BASE + 32'h4, 0, 0, 1, 32'h0, "wrap_c");
        cyc(BASE + 32'h10, 0, 0, 1, 32'h0, "wrap_noflag");

        // Collision: W1C on the match edge
        cyc(BASE + 32'h8, 0, 1);
        cyc(BASE + 32'h4, 0, 1);
        cyc(BASE + 32'h8, 7, 1);
        for (int i = 0; i < 3; i++) cyc(BASE + 32'h4, 0, 0, 1, i, "coll_count");
        cyc(BASE + 32'h10, 1, 1);
        cyc(BASE + 32'h10, 0, 0, 1, 32'h1, "coll_set_wins");
        // Collision: COUNT write on the match edge
        cyc(BASE + 32'h8, 0, 1);
        cyc(BASE + 32'h10, 1, 1);
        cyc(BASE + 32'h4, 0, 1);
        cyc(BASE + 32'h8, 3, 1);
        for (int i = 0; i < 3; i++) cyc(BASE + 32'h4, 0, 0, 1, i, "coll2_count");
        cyc(BASE + 32'h4, 100, 1, 1, 32'd3, "coll2_pre");
        cyc(BASE + 32'h4, 0, 0, 1, 32'd100, "coll2_count_wr");
        cyc(BASE + 32'h10, 0, 0, 1, 32'h0, "coll2_flag");

        // Reset mid-count with flag set
        cyc(BASE + 32'h8, 0, 1);
        cyc(BASE + 32'hC, 0, 1);
        cyc(BASE + 32'h4, 0, 1);
        cyc(BASE + 32'h8, 1, 1);
        cyc(BASE + 32'h8, 4, 1);
        cyc(BASE + 32'h4, 7, 1);
        cyc(BASE, 32'hA5, 1);
        check("pre_reset_irq", {31'h0, timer_irq}, 32'h1);
        @(negedge clk);
        clk_run = 1'b0;
        addr = BASE + 32'h4; mem_wr = 0;
        #2;
        check("pre_reset_count", rd_data, 32'd7);
        rst = 1'b0;
        #1;
        m_reset();
        check("rst_count", rd_data, 32'h0);
        check("rst_gpio", {24'h0, gpio_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        addr = BASE + 32'h10; #1;
        check("rst_flag", rd_data, 32'h0);
        addr = BASE + 32'h8; #1;
        check("rst_ctrl", rd_data, 32'h0);
        addr = BASE + 32'hC; #1;
        check("rst_compare", rd_data, 32'hFFFF_FFFF);
        #20;
        rst = 1'b1;
        #2;
        clk_run = 1'b1;
        cyc(32'h8, 0, 0, 1, 32'hDEAD_BEEF, "ram_after_reset");
        cyc(BASE + 32'h4, 0, 0, 1, 32'h0, "count_idle_after_reset");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [31:0] a, d;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                a = $urandom_range(0, 32'h0FFF);
            end else if (r < 9) begin
                a = BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            end else begin
                a = $urandom;
                if (a < BASE + 32'h20) a = a | 32'h8000_0000;
            end
            if (is_mmio(a) && (((a - BASE) >> 2) == 1 || ((a - BASE) >> 2) == 3))
                d = $urandom_range(0, 12);
            else
                d = $urandom;
            cyc(a, d, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
